// File: rtl/qsfp_monitor_scanner_if.sv
// qsfp_monitor_scanner_if: shadow-buffer read port, scan triggers and monitor-word stream of the QSFP scanner
interface qsfp_monitor_scanner_if #(
  parameter int QSFP_COUNT = 2
);
  localparam int MW = $clog2(QSFP_COUNT);
  logic start;
  logic updated;
  logic [MW+7:0] readAddress;
  logic [7:0] readData;
  logic freeze;
  logic [15:0] out_data;
  logic [MW-1:0] out_module;
  logic [2:0] out_item;
  logic out_valid;
  logic out_ready;
  logic out_last;
  logic busy;
  logic [15:0] scan_count;
  modport master (
    input start, updated, readData, out_ready,
    output readAddress, freeze, out_data, out_module, out_item, out_valid, out_last, busy, scan_count
  );
  modport slave (
    output start, updated, readData, out_ready,
    input readAddress, freeze, out_data, out_module, out_item, out_valid, out_last, busy, scan_count
  );
endinterface

// File: rtl/qsfp_monitor_scanner.sv
// qsfp_monitor_scanner: reads SFF-8636 monitor words from a frozen QSFP shadow buffer and streams them out
// QSFP_SCAN_RXPOWER_EN adds the four RX power words (items 2-5) per module
module qsfp_monitor_scanner #(
  parameter int QSFP_COUNT = 2,
  parameter int READ_LATENCY = 1
) (
  input logic clk,
  input logic reset,
  qsfp_monitor_scanner_if.master bus
);
  localparam int MW = $clog2(QSFP_COUNT);
  localparam logic [1:0] LAT_MAX = 2'(READ_LATENCY - 1);
  localparam logic [MW-1:0] LAST_MOD = MW'(QSFP_COUNT - 1);
`ifdef QSFP_SCAN_RXPOWER_EN
  localparam logic [2:0] LAST_ITEM = 3'd5;
`else
  localparam logic [2:0] LAST_ITEM = 3'd1;
`endif
  typedef enum logic [2:0] {IDLE, FREEZE, ADDR_HI, WAIT_HI, ADDR_LO, WAIT_LO, EMIT, DONE} state_t;
  state_t state_q, state_d;
  logic [MW-1:0] mod_q, mod_d, nxt_mod;
  logic [2:0] item_q, item_d, nxt_item;
  logic [1:0] lat_q, lat_d;
  logic [MW+7:0] addr_q, addr_d;
  logic [15:0] data_q, data_d, scan_count_q, scan_count_d;
  logic freeze_q, freeze_d, valid_q, valid_d, last_q, last_d, busy_q, busy_d;
  logic pend_q, pend_d, upd_q, upd_d, edge_w, lat_done;
  // high byte address of each word; the low byte always sits at the next (odd) address
  function automatic logic [7:0] item_addr(input logic [2:0] i);
`ifdef QSFP_SCAN_RXPOWER_EN
    return i == 3'd0 ? 8'd22 : i == 3'd1 ? 8'd26 : 8'd30 + {4'd0, i, 1'b0};
`else
    return i[0] ? 8'd26 : 8'd22;
`endif
  endfunction
  always_comb begin
    edge_w = bus.updated & ~upd_q;
    lat_done = lat_q == LAT_MAX;
    nxt_item = item_q == LAST_ITEM ? 3'd0 : item_q + 3'd1;
    nxt_mod = item_q == LAST_ITEM ? mod_q + 1'b1 : mod_q;
    state_d = state_q;
    mod_d = mod_q;
    item_d = item_q;
    lat_d = lat_q;
    addr_d = addr_q;
    data_d = data_q;
    freeze_d = freeze_q;
    valid_d = valid_q;
    last_d = last_q;
    scan_count_d = scan_count_q;
    upd_d = bus.updated;
    pend_d = pend_q | (edge_w & (state_q != IDLE));
    case (state_q)
      IDLE: if (bus.start | edge_w) begin
        state_d = FREEZE;
        freeze_d = 1'b1;
      end
      FREEZE: begin
        state_d = ADDR_HI;
        mod_d = '0;
        item_d = '0;
        addr_d = {MW'(0), item_addr(3'd0)};
      end
      ADDR_HI: begin
        state_d = WAIT_HI;
        lat_d = '0;
      end
      WAIT_HI: if (lat_done) begin
        data_d[15:8] = bus.readData;
        addr_d[0] = 1'b1;
        state_d = ADDR_LO;
      end else lat_d = lat_q + 2'd1;
      ADDR_LO: begin
        state_d = WAIT_LO;
        lat_d = '0;
      end
      WAIT_LO: if (lat_done) begin
        data_d[7:0] = bus.readData;
        valid_d = 1'b1;
        last_d = mod_q == LAST_MOD && item_q == LAST_ITEM;
        state_d = EMIT;
      end else lat_d = lat_q + 2'd1;
      EMIT: if (bus.out_ready) begin
        valid_d = 1'b0;
        last_d = 1'b0;
        if (last_q) begin
          state_d = DONE;
          freeze_d = 1'b0;
          scan_count_d = scan_count_q + 16'd1;
        end else begin
          state_d = ADDR_HI;
          mod_d = nxt_mod;
          item_d = nxt_item;
          addr_d = {nxt_mod, item_addr(nxt_item)};
        end
      end
      DONE: begin
        state_d = pend_d ? FREEZE : IDLE;
        freeze_d = pend_d;
        pend_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk)
    if (reset) begin
      state_q <= IDLE;
      mod_q <= '0;
      item_q <= '0;
      lat_q <= '0;
      addr_q <= '0;
      data_q <= '0;
      freeze_q <= 1'b0;
      valid_q <= 1'b0;
      last_q <= 1'b0;
      busy_q <= 1'b0;
      scan_count_q <= '0;
      pend_q <= 1'b0;
      upd_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mod_q <= mod_d;
      item_q <= item_d;
      lat_q <= lat_d;
      addr_q <= addr_d;
      data_q <= data_d;
      freeze_q <= freeze_d;
      valid_q <= valid_d;
      last_q <= last_d;
      busy_q <= busy_d;
      scan_count_q <= scan_count_d;
      pend_q <= pend_d;
      upd_q <= upd_d;
    end
  assign bus.readAddress = addr_q;
  assign bus.freeze = freeze_q;
  assign bus.out_data = data_q;
  assign bus.out_module = mod_q;
  assign bus.out_item = item_q;
  assign bus.out_valid = valid_q;
  assign bus.out_last = last_q;
  assign bus.busy = busy_q;
  assign bus.scan_count = scan_count_q;
endmodule

// File: tb/tb_qsfp_monitor_scanner.sv
// tb_qsfp_monitor_scanner: scoreboard bench with a shadow-buffer model and randomized contents/backpressure
module tb_qsfp_monitor_scanner;
  localparam int QC = 2;
  localparam int RL = 3;
  localparam int MW = $clog2(QC);
`ifdef QSFP_SCAN_RXPOWER_EN
  localparam int NI = 6;
`else
  localparam int NI = 2;
`endif
  localparam int BYTE_OF [6] = '{22, 26, 34, 36, 38, 40};
  typedef struct packed {
    logic [15:0] d;
    logic [MW-1:0] m;
    logic [2:0] i;
    logic l;
    logic f;
  } word_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [7:0] mem [QC][256];
  logic [7:0] pipe [RL];
  word_t sb[$];
  word_t got, exp_w;
  int tests = 0;
  int fails = 0;
  logic [15:0] exp_cnt = '0;
  bit rand_mode = 1'b0;
  qsfp_monitor_scanner_if #(.QSFP_COUNT(QC)) bus();
  qsfp_monitor_scanner #(.QSFP_COUNT(QC), .READ_LATENCY(RL)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  always #5 clk = ~clk;
  // shadow buffer: data for an address appears RL clocks after the address changes
  always @(posedge clk) begin
    pipe[0] <= mem[bus.readAddress[MW+7:8]][bus.readAddress[7:0]];
    for (int k = 1; k < RL; k++) pipe[k] <= pipe[k-1];
  end
  assign bus.readData = pipe[RL-1];

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic randomize_mem();
    for (int m = 0; m < QC; m++)
      for (int b = 0; b < 256; b++) mem[m][b] = 8'($urandom);
  endtask

  task automatic push_scan();
    for (int m = 0; m < QC; m++)
      for (int i = 0; i < NI; i++)
        sb.push_back('{d: {mem[m][BYTE_OF[i]], mem[m][BYTE_OF[i] + 1]}, m: MW'(m), i: 3'(i),
                       l: (m == QC - 1 && i == NI - 1), f: 1'b1});
  endtask

  task automatic launch(input int how);
    bus.start = how != 1;
    bus.updated = how != 0;
    tick(1);
    bus.start = 1'b0;
    bus.updated = 1'b0;
    push_scan();
    chk("freeze_on", 32'(bus.freeze), 32'd1);
    chk("busy_on", 32'(bus.busy), 32'd1);
  endtask

  task automatic scan_ok(input string name);
    int c = 0;
    while (bus.busy && c < 5000) begin
      tick(1);
      c++;
    end
    chk({name, "_timeout"}, 32'(c < 5000), 32'd1);
    chk({name, "_count"}, 32'(bus.scan_count), 32'(exp_cnt));
    chk({name, "_drain"}, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int c;
    logic [15:0] hd;
    logic [MW+7:0] ha;
    bit stable;
    bus.start = 1'b0;
    bus.updated = 1'b0;
    bus.out_ready = 1'b0;
    randomize_mem();
    fork
      forever begin
        @(negedge clk);
        if (!reset && bus.out_valid && bus.out_ready) begin
          got = '{d: bus.out_data, m: bus.out_module, i: bus.out_item, l: bus.out_last, f: bus.freeze};
          tests++;
          if (sb.size() == 0) begin
            fails++;
            $display("FAIL word: unexpected word %h", got);
          end else begin
            exp_w = sb.pop_front();
            if (got !== exp_w) begin
              fails++;
              $display("FAIL word: got %h, expected %h", got, exp_w);
            end
          end
        end
      end
      forever begin
        @(posedge clk);
        #1;
        if (rand_mode) bus.out_ready = $urandom_range(0, 3) != 0;
      end
    join_none
    tick(3);
    reset = 1'b0;
    chk("rst_freeze", 32'(bus.freeze), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_last", 32'(bus.out_last), 32'd0);
    chk("rst_addr", 32'(bus.readAddress), 32'd0);
    chk("rst_data", 32'(bus.out_data), 32'd0);
    chk("rst_module", 32'(bus.out_module), 32'd0);
    chk("rst_item", 32'(bus.out_item), 32'd0);
    chk("rst_count", 32'(bus.scan_count), 32'd0);
    // random contents, random backpressure, all three trigger styles
    for (int t = 0; t < 6; t++) begin
      randomize_mem();
      rand_mode = 1'b1;
      launch(t % 3);
      exp_cnt++;
      scan_ok("rand");
      tick(2);
    end
    // stall on the third word of the scan
    rand_mode = 1'b0;
    bus.out_ready = 1'b1;
    randomize_mem();
    launch(0);
    exp_cnt++;
    c = 0;
    while (sb.size() > QC * NI - 2 && c < 2000) begin
      tick(1);
      c++;
    end
    bus.out_ready = 1'b0;
    c = 0;
    while (!bus.out_valid && c < 2000) begin
      tick(1);
      c++;
    end
    chk("stall_reach", 32'(c < 2000), 32'd1);
    hd = bus.out_data;
    ha = bus.readAddress;
    stable = 1'b1;
    repeat (50) begin
      tick(1);
      if (bus.out_data !== hd || bus.readAddress !== ha || !bus.out_valid || !bus.freeze) stable = 1'b0;
    end
    chk("stall_stable", 32'(stable), 32'd1);
    chk("stall_item", 32'(bus.out_item), 32'(2 % NI));
    chk("stall_module", 32'(bus.out_module), 32'(2 / NI));
    bus.out_ready = 1'b1;
    scan_ok("stall");
    tick(2);
    // three updated edges mid-scan collapse into one extra scan
    rand_mode = 1'b1;
    launch(0);
    push_scan();
    exp_cnt = exp_cnt + 16'd2;
    tick(3);
    repeat (3) begin
      bus.updated = 1'b1;
      tick(2);
      bus.updated = 1'b0;
      tick(2);
    end
    scan_ok("pending");
    tick(2);
    // reset in WAIT_LO of the last module aborts the scan cleanly
    rand_mode = 1'b0;
    bus.out_ready = 1'b1;
    launch(0);
    c = 0;
    while (bus.readAddress !== {MW'(QC - 1), 8'd23} && c < 2000) begin
      tick(1);
      c++;
    end
    chk("rst_reach", 32'(c < 2000), 32'd1);
    tick(1);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    exp_cnt = '0;
    chk("abort_freeze", 32'(bus.freeze), 32'd0);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_valid", 32'(bus.out_valid), 32'd0);
    chk("abort_count", 32'(bus.scan_count), 32'd0);
    chk("abort_left", 32'(sb.size()), 32'(NI));
    sb.delete();
    tick(20);
    randomize_mem();
    launch(0);
    exp_cnt++;
    scan_ok("after_rst");
    tick(2);
    // counter wrap from a preset of 0xFFFF
    force dut.scan_count_q = 16'hFFFF;
    tick(1);
    release dut.scan_count_q;
    tick(1);
    chk("preset", 32'(bus.scan_count), 32'hFFFF);
    exp_cnt = 16'hFFFF;
    rand_mode = 1'b1;
    launch(0);
    exp_cnt++;
    scan_ok("wrap");
    chk("wrap_zero", 32'(bus.scan_count), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/qsfp_monitor_scanner.md
QSFP_MONITOR_SCANNER -- requirements
Module: qsfp_monitor_scanner

Interface
REQ-001 Parameter QSFP_COUNT, default 2, number of QSFP modules served by the shadow buffer; SHALL be >= 2.
REQ-002 Parameter READ_LATENCY, default 1, clocks from readAddress change to valid readData; legal range 1..4.
REQ-003 clk  input  1  system clock; all logic SHALL be synchronous to its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  single-cycle scan request.
REQ-006 updated  input  1  shadow-buffer refresh flag from the I2C poller; rising edge requests a scan.
REQ-007 readAddress  output  $clog2(QSFP_COUNT)+8  {module index, byte address[7:0]} into the shadow buffer.
REQ-008 readData  input  8  shadow-buffer byte.
REQ-009 freeze  output  1  holds the shadow buffer constant while asserted.
REQ-010 out_data  output  16  assembled monitor word.
REQ-011 out_module  output  $clog2(QSFP_COUNT)  source module of out_data.
REQ-012 out_item  output  3  word index within the module (table in REQ-016).
REQ-013 out_valid / out_ready  output / input  1 / 1  stream handshake; transfer on out_valid & out_ready.
REQ-014 out_last  output  1  marks the final word of a scan.
REQ-015 busy  output  1 / scan_count  output  16  scan in progress / completed-scan counter.

Function
REQ-016 Word table (SFF-8636 lower page, big-endian, high byte at the lower address): item 0 temperature bytes 22-23; item 1 Vcc bytes 26-27; items 2-5 RX power ch1-4 bytes 34-35, 36-37, 38-39, 40-41.
REQ-017 FSM states SHALL be IDLE, FREEZE, ADDR_HI, WAIT_HI, ADDR_LO, WAIT_LO, EMIT, DONE.
REQ-018 IDLE -> FREEZE on start, or on the rising edge of updated; freeze SHALL assert in FREEZE and remain asserted through DONE.
REQ-019 FREEZE SHALL last exactly one cycle, then go to ADDR_HI for module 0, item 0.
REQ-020 ADDR_x SHALL drive readAddress; WAIT_x SHALL count READ_LATENCY cycles, then capture readData into the high or low byte.
REQ-021 EMIT SHALL present out_valid=1 with stable out_data/out_module/out_item until the handshake completes; the FSM SHALL stall indefinitely while out_ready=0.
REQ-022 After the handshake, the item SHALL advance, then the module; after the final word the FSM SHALL enter DONE.
REQ-023 out_last SHALL be 1 only on the word for module QSFP_COUNT-1, final item.
REQ-024 DONE SHALL deassert freeze, increment scan_count (16-bit, wraps 0xFFFF -> 0x0000), and return to IDLE after one cycle.
REQ-025 start during a scan SHALL be ignored; an updated rising edge during a scan SHALL set a pending flag, causing exactly one further scan directly after DONE regardless of how many edges occurred.
REQ-026 start and an updated edge in the same IDLE cycle SHALL launch one scan only.
REQ-027 busy SHALL be 1 in every state except IDLE.

Reset
REQ-028 On reset: state IDLE; freeze, out_valid, out_last, and busy 0; readAddress, out_data, out_module, out_item, scan_count, and pending flag 0; updated edge detector primed with 0.
REQ-029 Reset asserted mid-scan SHALL abort the scan; freeze SHALL be 0 in the cycle after reset is sampled, and no partial word SHALL be emitted.

Configuration
REQ-030 Macro QSFP_SCAN_RXPOWER_EN: when defined, each module SHALL yield items 0-5 (six words); when undefined, items 0-1 only (two words), with out_last on item 1 and RX-power logic absent.

Verification
REQ-031 QSFP_COUNT=2, RXPOWER_EN defined, module0 bytes 22/23=0x1A/0x80, out_ready=1, pulse start -> first word 0x1A80, module 0, item 0; 12 words total; out_last on module 1, item 5; scan_count 0 -> 1; freeze high from the cycle after start until DONE.
REQ-032 out_ready held 0 for 50 cycles on item 2 -> out_data stable, freeze remains 1, no readAddress change; the scan resumes on release.
REQ-033 Three updated edges during a scan -> exactly two scans total; scan_count ends at 2.
REQ-034 Reset pulsed during WAIT_LO of module 1 -> the next cycle shows freeze=0, busy=0, out_valid=0; a subsequent start yields a complete scan.
REQ-035 RXPOWER_EN undefined, READ_LATENCY=3 -> 4 words, byte-capture timing honoured, out_last on module 1, item 1.
REQ-036 scan_count preset by 65535 scans -> the next DONE wraps it to 0x0000.
